// File: rtl/alarm_pkg.sv
// alarm_pkg: state encoding, 7-segment codes and BCD helpers shared by alarm_sequencer.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_ALARM  = 2'b10,
    ST_SNOOZE = 2'b11
  } state_e;

  // Two-digit BCD value, tens in the upper nibble.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Active-low digit commons.
  localparam logic [1:0] COM_ONES = 2'b10;
  localparam logic [1:0] COM_TENS = 2'b01;

  // Segment codes, bit order gfedcba, active-high.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1100111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // 00..99 BCD increment, 99 wraps to 00.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = (v.tens == 4'd9) ? 4'd0 : v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running divider producing a one-cycle tick every DIV enabled cycles.
// Latency: tick is combinational from the counter; first tick DIV cycles after clear/enable.
// Backpressure: none; clr and en are sampled every cycle.
// Ports: clk/rst_n clock and async active-low reset; clr forces the count to 0;
//        en lets the count advance (held at 0 when low); tick pulses when count == DIV-1.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || !en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: BCD 00-99 seconds counter with alarm/snooze FSM and 2-digit 7-seg scan.
// Latency: control pulses take effect on the next edge; o/com/sp/busy are registered.
// Backpressure: none; start/stop/snooze are one-cycle pulses sampled every cycle.
// Ports: clk, rst_n (async active-low); start/stop/snooze control pulses;
//        o segments gfedcba of the selected digit; com active-low commons (10=ones, 01=tens);
//        sp speaker enable; busy high outside IDLE; state current FSM state.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int TICK_DIV     = 10000000,
  parameter int SCAN_DIV     = 50000,
  parameter int ALARM_TENS   = 1,
  parameter int ALARM_ONES   = 9,
  parameter int BEEP_TICKS   = 5,
  parameter int SNOOZE_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       snooze,
  output logic [6:0] o,
  output logic [1:0] com,
  output logic       sp,
  output logic       busy,
  output logic [1:0] state
);

  localparam int BW = $clog2(BEEP_TICKS + 1);
  localparam int SW = $clog2(SNOOZE_TICKS + 1);

  localparam bcd2_t         ALARM_VAL = '{tens: 4'(ALARM_TENS), ones: 4'(ALARM_ONES)};
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_TICKS - 1);

  state_e        state_q, state_d;
  bcd2_t         digits_q, digits_d, digits_inc;
  logic [BW-1:0] beep_q, beep_d;
  logic [SW-1:0] snz_q, snz_d;
  logic [1:0]    com_q, com_d;
  logic [6:0]    o_q;
  logic          sp_q, busy_q;
  logic [3:0]    sel_digit;
  logic          cnt_tick, scan_tick;

  // Count prescaler: idle in IDLE and restarted on every state change so
  // each state sees a full TICK_DIV period before its first tick.
  tick_gen #(.DIV(TICK_DIV)) u_cnt_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_d != state_q),
    .en   (state_q != ST_IDLE),
    .tick (cnt_tick)
  );

  tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (1'b0),
    .en   (1'b1),
    .tick (scan_tick)
  );

  assign digits_inc = bcd_inc(digits_q);

  // Next-state: stop > snooze > start > tick. Ignored controls fall through
  // so a tick still lands in the same cycle.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    beep_d   = beep_q;
    snz_d    = snz_q;
    if (stop) begin
      state_d  = ST_IDLE;
      digits_d = '0;
    end else if (snooze && state_q == ST_ALARM) begin
      state_d = ST_SNOOZE;
    end else if (start && state_q == ST_IDLE) begin
      state_d = ST_RUN;
    end else if (cnt_tick) begin
      case (state_q)
        ST_RUN: begin
          digits_d = digits_inc;
          if (digits_inc == ALARM_VAL) state_d = ST_ALARM;
        end
        ST_ALARM: begin
          if (beep_q == BEEP_LAST) begin
            state_d  = ST_IDLE;
            digits_d = '0;
          end else begin
            beep_d = beep_q + BW'(1);
          end
        end
        ST_SNOOZE: begin
          if (snz_q == SNZ_LAST) state_d = ST_ALARM;
          else                   snz_d   = snz_q + SW'(1);
        end
        default: ;
      endcase
    end
    // Tick counters are per-visit: every entry into ALARM/SNOOZE starts at 0.
    if (state_d != state_q) begin
      beep_d = '0;
      snz_d  = '0;
    end
  end

  // Display: the registered o is built from next-cycle com and digits so it
  // always matches the com value and count it is shown with.
  always_comb begin
    com_d     = scan_tick ? ~com_q : com_q;
    sel_digit = (com_d == COM_ONES) ? digits_d.ones : digits_d.tens;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      digits_q <= '0;
      beep_q   <= '0;
      snz_q    <= '0;
      com_q    <= COM_ONES;
      o_q      <= SEG_0;
      sp_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      beep_q   <= beep_d;
      snz_q    <= snz_d;
      com_q    <= com_d;
      o_q      <= seg7(sel_digit);
      sp_q     <= (state_d == ST_ALARM);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign o     = o_q;
  assign com   = com_q;
  assign sp    = sp_q;
  assign busy  = busy_q;
  assign state = state_q;

endmodule
